// File: rtl/axi_rd_sched_if.sv
// AXI4 read-address and read-data channels between the read scheduler and the memory-side slave.
interface axi_rd_sched_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256,
   parameter int ID_WIDTH   = 4
);
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/axi_rd_sched.sv
// Round-robin read scheduler: shares one AXI read channel among tensor loaders,
// splits each transfer into INCR bursts and steers returned beats to the owner.
//
//  state  | meaning
//  IDLE   | pick next requester round-robin and capture its transfer
//  ADDR   | present one burst on AR, hold until accepted
//  DATA   | forward R beats to the owner until rlast
//  DONE   | one-cycle completion/error pulse to the owner
module axi_rd_sched #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 256,
   parameter int ID_WIDTH   = 4,
   parameter int NUM_REQ    = 3,
   parameter int MAX_BURST  = 16,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                            aclk_i,
   input  logic                            areset_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_beats_i,
   axi_rd_sched_if.master                  m_axi,
   output logic [DATA_WIDTH-1:0]           rd_data_o,
   output logic [NUM_REQ-1:0]              rd_valid_o,
   input  logic [NUM_REQ-1:0]              rd_ready_i,
   output logic [LEN_WIDTH-1:0]            rd_beat_o,
   output logic [NUM_REQ-1:0]              rd_done_o,
   output logic [NUM_REQ-1:0]              rd_err_o
);
   localparam int                   OW      = $clog2(NUM_REQ);
   localparam logic [2:0]           AR_SIZE = 3'($clog2(DATA_WIDTH/8));
   localparam logic [LEN_WIDTH-1:0] MAX_B   = LEN_WIDTH'(MAX_BURST);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [OW-1:0]         rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]         owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
   logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [LEN_WIDTH-1:0]  burst_len_q, burst_len_d;
   logic                  err_q, err_d;

   logic [OW-1:0]         grant_idx, cand;
   logic                  grant_vld;
   logic [LEN_WIDTH-1:0]  cur_beats;
   logic [ADDR_WIDTH-1:0] req_addr_a  [NUM_REQ];
   logic [LEN_WIDTH-1:0]  req_beats_a [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_addr_a[g]  = req_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign req_beats_a[g] = req_beats_i[g*LEN_WIDTH +: LEN_WIDTH];
   end

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = OW'((int'(rr_ptr_q) + i) % NUM_REQ);
         if (!grant_vld && req_valid_i[cand]) begin
            grant_vld = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign cur_beats = (remaining_q > MAX_B) ? MAX_B : remaining_q;
   assign rd_data_o = m_axi.rdata;
   assign rd_beat_o = beat_cnt_q;

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      owner_d         = owner_q;
      addr_d          = addr_q;
      remaining_d     = remaining_q;
      beat_cnt_d      = beat_cnt_q;
      burst_len_d     = burst_len_q;
      err_d           = err_q;
      req_ready_o     = '0;
      rd_valid_o      = '0;
      rd_done_o       = '0;
      rd_err_o        = '0;
      m_axi.arvalid   = 1'b0;
      m_axi.arid      = '0;
      m_axi.araddr    = '0;
      m_axi.arlen     = '0;
      m_axi.arsize    = '0;
      m_axi.arburst   = '0;
      m_axi.rready    = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Gated by reset so nothing is acknowledged that the reset then discards.
            if (grant_vld && !areset_i) begin
               req_ready_o[grant_idx] = 1'b1;
               owner_d     = grant_idx;
               addr_d      = req_addr_a[grant_idx];
               remaining_d = req_beats_a[grant_idx];
               beat_cnt_d  = '0;
               err_d       = 1'b0;
               rr_ptr_d    = OW'((int'(grant_idx) + 1) % NUM_REQ);
               state_d     = (req_beats_a[grant_idx] == '0) ? S_DONE : S_ADDR;
            end
         end
         S_ADDR: begin
            m_axi.arvalid = 1'b1;
            m_axi.arid    = ID_WIDTH'(owner_q);
            m_axi.araddr  = addr_q;
            m_axi.arlen   = 8'(cur_beats - 1'b1);
            m_axi.arsize  = AR_SIZE;
            m_axi.arburst = 2'b01;
            if (m_axi.arready) begin
               burst_len_d = cur_beats;
               state_d     = S_DATA;
            end
         end
         S_DATA: begin
            m_axi.rready          = rd_ready_i[owner_q];
            rd_valid_o[owner_q]   = m_axi.rvalid;
            if (m_axi.rvalid && rd_ready_i[owner_q]) begin
               beat_cnt_d  = beat_cnt_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (m_axi.rresp != 2'b00 || m_axi.rid != ID_WIDTH'(owner_q)) err_d = 1'b1;
               // Only rlast ends a burst; the beat count is informational.
               if (m_axi.rlast) begin
                  addr_d  = addr_q + (ADDR_WIDTH'(burst_len_q) << AR_SIZE);
                  state_d = (remaining_d != '0) ? S_ADDR : S_DONE;
               end
            end
         end
         S_DONE: begin
            rd_done_o[owner_q] = 1'b1;
            rd_err_o[owner_q]  = err_q;
            state_d            = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge aclk_i) begin
      if (areset_i) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         addr_q      <= '0;
         remaining_q <= '0;
         beat_cnt_q  <= '0;
         burst_len_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         beat_cnt_q  <= beat_cnt_d;
         burst_len_q <= burst_len_d;
         err_q       <= err_d;
      end
   end
endmodule

// File: tb/tb_axi_rd_sched.sv
// Directed bench for axi_rd_sched: table of single transfers plus hand-written
// arbitration and mid-transfer reset sequences, with a behavioural AXI slave.
module tb_axi_rd_sched;
   localparam int AW = 32;
   localparam int DW = 256;
   localparam int IW = 4;
   localparam int NR = 3;
   localparam int MB = 16;
   localparam int LW = 16;

   logic              aclk_i = 1'b0;
   logic              areset_i;
   logic [NR-1:0]     req_valid_i;
   logic [NR-1:0]     req_ready_o;
   logic [NR*AW-1:0]  req_addr_i;
   logic [NR*LW-1:0]  req_beats_i;
   logic [DW-1:0]     rd_data_o;
   logic [NR-1:0]     rd_valid_o;
   logic [NR-1:0]     rd_ready_i;
   logic [LW-1:0]     rd_beat_o;
   logic [NR-1:0]     rd_done_o;
   logic [NR-1:0]     rd_err_o;

   logic [AW-1:0]     ra [NR];
   logic [LW-1:0]     rb [NR];
   assign req_addr_i  = {ra[2], ra[1], ra[0]};
   assign req_beats_i = {rb[2], rb[1], rb[0]};

   axi_rd_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

   axi_rd_sched #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
      .NUM_REQ(NR), .MAX_BURST(MB), .LEN_WIDTH(LW)
   ) dut (
      .aclk_i      (aclk_i),
      .areset_i    (areset_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_beats_i (req_beats_i),
      .m_axi       (axi),
      .rd_data_o   (rd_data_o),
      .rd_valid_o  (rd_valid_o),
      .rd_ready_i  (rd_ready_i),
      .rd_beat_o   (rd_beat_o),
      .rd_done_o   (rd_done_o),
      .rd_err_o    (rd_err_o)
   );

   always #5 aclk_i = ~aclk_i;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      int            r;
      logic [AW-1:0] addr;
      int            beats;
      int            err_beat;
      bit            rid_bad;
      int            stall_at;
      int            nar;
      int            last_len;
      bit            err;
   } vec_t;

   vec_t vecs [9];

   // Called at a negedge. Requests transfer r, plays the AXI slave and owner,
   // and returns at the negedge of the rd_done cycle (or right after an abort).
   task automatic run_xfer(input int r, input logic [AW-1:0] a, input int beats,
                           input int err_beat, input bit rid_bad, input int stall_at,
                           input int exp_nar, input int exp_last, input bit exp_err,
                           input logic [NR-1:0] raise_mask, input int abort_ar,
                           input int exp_wait);
      int            beat_idx, ar_idx, burst_left, stall, last_hs, cyc, wait_c;
      bit            in_burst, got_done, rv;
      logic [NR-1:0] oh, exp_e;
      logic [AW-1:0] exp_addr;
      beat_idx = 0; ar_idx = 0; burst_left = 0; stall = 0; last_hs = 0; cyc = 0; wait_c = 0;
      in_burst = 0; got_done = 0; rv = 0;
      oh    = NR'(1) << r;
      exp_e = exp_err ? oh : '0;
      ra[r] = a;
      rb[r] = LW'(beats);
      req_valid_i[2'(r)] = 1'b1;
      #1;
      while (req_ready_o == '0 && wait_c < 50) begin
         @(negedge aclk_i); #1;
         wait_c++;
      end
      chk("grant", req_ready_o, oh);
      if (exp_wait >= 0) chk("grant_wait", wait_c, exp_wait);

      while (!got_done && cyc < 400) begin
         @(posedge aclk_i); #1;
         cyc++;
         if (cyc == 2) begin
            req_valid_i[2'(r)] = 1'b0;
            req_valid_i = req_valid_i | raise_mask;
         end
         axi.arready = (ar_idx != abort_ar);
         rv          = in_burst;
         axi.rvalid  = rv;
         axi.rlast   = in_burst && burst_left == 1;
         axi.rresp   = (rv && beat_idx == err_beat && !rid_bad) ? 2'b10 : 2'b00;
         axi.rid     = (rv && beat_idx == err_beat && rid_bad) ? IW'(r + 1) : IW'(r);
         axi.rdata   = {8{16'(beat_idx), 16'(r)}};
         rd_ready_i[2'(r)] = !(stall_at >= 0 && beat_idx == stall_at && stall < 5);
         @(negedge aclk_i);
         if (cyc == 1) chk("req_ready_pulse", req_ready_o, 0);
         if (rv) begin
            chk("rd_valid", rd_valid_o, oh);
            chk("rd_beat", rd_beat_o, beat_idx);
            chk("rd_data", rd_data_o, axi.rdata);
            chk("rready", axi.rready, rd_ready_i[2'(r)]);
            if (!rd_ready_i[2'(r)]) stall++;
            else begin
               beat_idx++;
               burst_left--;
               if (burst_left == 0) begin
                  in_burst = 0;
                  last_hs  = cyc;
               end
            end
         end else begin
            chk("rd_valid_idle", rd_valid_o, 0);
         end
         if (axi.arvalid) begin
            exp_addr = a + AW'(ar_idx * MB * DW / 8);
            chk("ar_overlap", in_burst, 0);
            chk("ar_cycle", cyc, (ar_idx == 0) ? 1 : last_hs + 1);
            chk("araddr", axi.araddr, exp_addr);
            chk("arlen", axi.arlen, (ar_idx == exp_nar - 1) ? exp_last : MB - 1);
            chk("arid", axi.arid, r);
            chk("arsize", axi.arsize, 5);
            chk("arburst", axi.arburst, 1);
            if (ar_idx == abort_ar) begin
               areset_i = 1'b1;
               @(negedge aclk_i);
               chk("abort_arvalid", axi.arvalid, 0);
               chk("abort_rready", axi.rready, 0);
               chk("abort_done", rd_done_o, 0);
               chk("abort_rd_beat", rd_beat_o, 0);
               areset_i = 1'b0;
               return;
            end
            in_burst   = 1;
            burst_left = int'(axi.arlen) + 1;
            ar_idx++;
         end
         if (rd_done_o != '0) begin
            chk("rd_done", rd_done_o, oh);
            chk("rd_err", rd_err_o, exp_e);
            chk("beats_delivered", beat_idx, beats);
            chk("ar_count", ar_idx, exp_nar);
            chk("done_cycle", cyc, (beats == 0) ? 1 : last_hs + 1);
            if (stall_at >= 0) chk("stall_cycles", stall, 5);
            got_done = 1;
         end
      end
      if (!got_done && abort_ar < 0) chk("xfer_timeout", got_done, 1);
   endtask

   initial begin
      //               r  addr           beats err rid stall nar last err
      vecs[0] = '{0, 32'h0000_1000, 40, -1, 0, -1, 3, 7,  0};
      vecs[1] = '{1, 32'h0000_2000, 20, -1, 0,  6, 2, 3,  0};
      vecs[2] = '{2, 32'h0000_3000,  8,  3, 0, -1, 1, 7,  1};
      vecs[3] = '{0, 32'h0000_4000,  8, -1, 0, -1, 1, 7,  0};
      vecs[4] = '{1, 32'h0000_5000,  0, -1, 0, -1, 0, 0,  0};
      vecs[5] = '{2, 32'h0000_6000, 16, -1, 0, -1, 1, 15, 0};
      vecs[6] = '{0, 32'h0000_7000, 17, -1, 0, -1, 2, 0,  0};
      vecs[7] = '{1, 32'hFFFF_FC00, 48, -1, 0, -1, 3, 15, 0};
      vecs[8] = '{2, 32'h0000_9000,  4,  0, 1, -1, 1, 3,  1};

      areset_i    = 1'b1;
      rd_ready_i  = '1;
      axi.arready = 1'b0;
      axi.rvalid  = 1'b0;
      axi.rlast   = 1'b0;
      axi.rresp   = 2'b00;
      axi.rid     = '0;
      axi.rdata   = '0;
      ra[0] = 32'h100; ra[1] = 32'h200; ra[2] = 32'h300;
      rb[0] = 16'd4;   rb[1] = 16'd4;   rb[2] = 16'd4;
      req_valid_i = 3'b111;

      repeat (2) @(posedge aclk_i);
      @(negedge aclk_i);
      chk("rst_arvalid", axi.arvalid, 0);
      chk("rst_rready", axi.rready, 0);
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_rd_valid", rd_valid_o, 0);
      chk("rst_rd_done", rd_done_o, 0);
      chk("rst_rd_err", rd_err_o, 0);
      chk("rst_rd_beat", rd_beat_o, 0);
      chk("rst_ar_payload", {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst}, 0);

      // All three valid at reset release: 0,1,2 in order; 0 re-requests during 2 and wins over 1.
      areset_i = 1'b0;
      run_xfer(0, 32'h100, 4, -1, 0, -1, 1, 3, 0, 3'b000, -1, 0);
      run_xfer(1, 32'h200, 4, -1, 0, -1, 1, 3, 0, 3'b000, -1, 1);
      run_xfer(2, 32'h300, 4, -1, 0, -1, 1, 3, 0, 3'b011, -1, 1);
      run_xfer(0, 32'h400, 4, -1, 0, -1, 1, 3, 0, 3'b000, -1, 1);
      run_xfer(1, 32'h500, 4, -1, 0, -1, 1, 3, 0, 3'b000, -1, 1);

      for (int i = 0; i < 9; i++) begin
         run_xfer(vecs[i].r, vecs[i].addr, vecs[i].beats, vecs[i].err_beat, vecs[i].rid_bad,
                  vecs[i].stall_at, vecs[i].nar, vecs[i].last_len, vecs[i].err,
                  3'b000, -1, -1);
      end

      // Reset while the second burst is presented; afterwards arbitration restarts at 0.
      run_xfer(1, 32'h0000_1000, 40, -1, 0, -1, 3, 7, 0, 3'b000, 1, -1);
      ra[2] = 32'h0000_A000;
      rb[2] = 16'd2;
      req_valid_i[2] = 1'b1;
      run_xfer(0, 32'h0000_B000, 2, -1, 0, -1, 1, 1, 0, 3'b000, -1, 0);
      run_xfer(2, 32'h0000_A000, 2, -1, 0, -1, 1, 1, 0, 3'b000, -1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
